// File: rtl/pt_pkg.sv
// Shared PT2262 definitions: FSM states, pulse-width classes and alpha ratios.
// pt_enc reuses HALF_BITS and the *_A ratios.
package pt_pkg;

   typedef enum logic [2:0] {IDLE, WAIT_H, HIGH, LOW, SYNC_H, SYNC_L} state_t;
   typedef enum logic [1:0] {W_GLITCH, W_SHORT, W_LONG, W_OVER} width_t;

   localparam int HALF_BITS   = 24;
   localparam int SHORT_MIN_A = 2;
   localparam int LONG_MIN_A  = 8;
   localparam int LONG_MAX_A  = 16;

   // Pulse width w is in clk cycles; alpha is clk cycles per encoder alpha.
   function automatic width_t classify(input logic [31:0] w, input int alpha);
      if (w < 32'(SHORT_MIN_A * alpha)) return W_GLITCH;
      if (w < 32'(LONG_MIN_A * alpha))  return W_SHORT;
      if (w <= 32'(LONG_MAX_A * alpha)) return W_LONG;
      return W_OVER;
   endfunction

endpackage

// File: rtl/pt_sync.sv
// Two-flop synchronizer for the serial line plus registered rise/fall pulses.
// level, rise and fall all change on the same clock edge.
module pt_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic level,
   output logic rise,
   output logic fall
);

   logic meta;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta   <= 1'b0;
         sync_q <= 1'b0;
         level  <= 1'b0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         meta   <= d;
         sync_q <= meta;
         level  <= sync_q;
         rise   <= sync_q & ~level;
         fall   <= ~sync_q & level;
      end
   end

endmodule

// File: rtl/pt_dec.sv
// PT2262-style frame decoder: measures pulse widths and rebuilds a 24-bit word.
// Optional PT_DEC_CONFIRM_EN: publish a frame only when it repeats the previous one.
module pt_dec
   import pt_pkg::*;
#(
   parameter int ALPHA    = 4,
   parameter int SYNC_MIN = 64,
   parameter int CNT_W    = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 d,
   output logic [HALF_BITS-1:0] ad,
   output logic                 valid,
   output logic                 err,
   output logic                 act
);

   localparam logic [CNT_W-1:0] SYNC_CNT = CNT_W'(SYNC_MIN * ALPHA);
   localparam logic [CNT_W-1:0] LOW_MAX  = CNT_W'(LONG_MAX_A * ALPHA);
   localparam logic [4:0]       LAST_BIT = 5'(HALF_BITS - 1);

   logic                 level, rise, fall;
   logic [CNT_W-1:0]     cnt;
   width_t               w_cls;
   state_t               state;
   logic [4:0]           bits;
   logic [HALF_BITS-1:0] sr;
   logic                 hi_long;
   logic                 accept;
   logic                 confirmed;

   pt_sync u_sync (
      .clk   (clk),
      .rst   (rst),
      .d     (d),
      .level (level),
      .rise  (rise),
      .fall  (fall)
   );

   // Width of the current level in clk cycles; the edge cycle itself counts as 1.
   always_ff @(posedge clk) begin
      if (rst)                cnt <= '0;
      else if (rise || fall)  cnt <= CNT_W'(1);
      else if (cnt != '1)     cnt <= cnt + CNT_W'(1);
   end

   assign w_cls  = classify(32'(cnt), ALPHA);
   assign accept = (state == SYNC_L) && (cnt >= SYNC_CNT);

`ifdef PT_DEC_CONFIRM_EN
   logic [HALF_BITS-1:0] ref_word;
   logic                 ref_ok;

   always_ff @(posedge clk) begin
      if (rst || err) ref_ok <= 1'b0;
      else if (accept) ref_ok <= 1'b1;
   end

   // NOTE: ref_word is storage qualified by ref_ok, so it needs no reset.
   always_ff @(posedge clk) begin
      if (accept) ref_word <= sr;
   end

   assign confirmed = ref_ok && (ref_word == sr);
`else
   assign confirmed = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         bits    <= '0;
         sr      <= '0;
         hi_long <= 1'b0;
         ad      <= '0;
         valid   <= 1'b0;
         err     <= 1'b0;
         act     <= 1'b0;
      end else begin
         valid <= 1'b0;
         err   <= 1'b0;
         case (state)
            IDLE: begin
               if (!level && cnt >= SYNC_CNT) state <= WAIT_H;
            end
            WAIT_H: begin
               if (rise) begin
                  state <= HIGH;
                  bits  <= '0;
                  act   <= 1'b1;
               end
            end
            HIGH: begin
               if (fall) begin
                  if (w_cls == W_SHORT || w_cls == W_LONG) begin
                     hi_long <= (w_cls == W_LONG);
                     state   <= LOW;
                  end else begin
                     err   <= 1'b1;
                     act   <= 1'b0;
                     state <= IDLE;
                  end
               end
            end
            LOW: begin
               if (rise) begin
                  // Only short-high/long-low (0) and long-high/short-low (1) are legal.
                  if ((!hi_long && w_cls == W_LONG) || (hi_long && w_cls == W_SHORT)) begin
                     sr    <= {sr[HALF_BITS-2:0], hi_long};
                     bits  <= bits + 5'd1;
                     state <= (bits == LAST_BIT) ? SYNC_H : HIGH;
                  end else begin
                     err   <= 1'b1;
                     act   <= 1'b0;
                     state <= IDLE;
                  end
               end else if (cnt > LOW_MAX) begin
                  err   <= 1'b1;
                  act   <= 1'b0;
                  state <= IDLE;
               end
            end
            SYNC_H: begin
               if (fall) begin
                  if (w_cls == W_SHORT) begin
                     state <= SYNC_L;
                  end else begin
                     err   <= 1'b1;
                     act   <= 1'b0;
                     state <= IDLE;
                  end
               end
            end
            SYNC_L: begin
               if (accept) begin
                  if (confirmed) begin
                     ad    <= sr;
                     valid <= 1'b1;
                  end
                  // A rise landing exactly on the threshold already starts the next frame.
                  bits  <= '0;
                  act   <= rise;
                  state <= rise ? HIGH : WAIT_H;
               end else if (rise) begin
                  err   <= 1'b1;
                  act   <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               act   <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pt_dec.sv
// Scoreboard bench for pt_dec: stimulus pushes expected valid/err events,
// a monitor pops and compares them whenever the decoder pulses.
module tb_pt_dec;

   localparam int ALPHA = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        d;
   logic [23:0] ad;
   logic        valid, err, act;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic        is_err;
      logic [23:0] word;
   } ev_t;

   ev_t         exp_q[$];
   logic [23:0] model_ad = '0;
`ifdef PT_DEC_CONFIRM_EN
   logic        ref_ok = 1'b0;
   logic [23:0] ref_w  = '0;
`endif

   pt_dec #(.ALPHA(ALPHA), .SYNC_MIN(64), .CNT_W(10)) dut (
      .clk   (clk),
      .rst   (rst),
      .d     (d),
      .ad    (ad),
      .valid (valid),
      .err   (err),
      .act   (act)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, got, want);
      end
   endtask

   task automatic exp_good(input logic [23:0] w);
`ifdef PT_DEC_CONFIRM_EN
      if (ref_ok && ref_w == w) begin
         exp_q.push_back('{1'b0, w});
         model_ad = w;
      end
      ref_w  = w;
      ref_ok = 1'b1;
`else
      exp_q.push_back('{1'b0, w});
      model_ad = w;
`endif
   endtask

   task automatic exp_err();
      exp_q.push_back('{1'b1, 24'h0});
`ifdef PT_DEC_CONFIRM_EN
      ref_ok = 1'b0;
`endif
   endtask

   task automatic hold(input logic v, input int a);
      d = v;
      repeat (a * ALPHA) @(negedge clk);
   endtask

   task automatic half(input logic b);
      if (b) begin hold(1'b1, 12); hold(1'b0, 4);  end
      else   begin hold(1'b1, 4);  hold(1'b0, 12); end
   endtask

   task automatic send_bits(input logic [23:0] w, input int from, input int to);
      for (int i = from; i <= to; i++) half(w[23-i]);
   endtask

   task automatic send_sync(input int low_a);
      hold(1'b1, 4);
      hold(1'b0, low_a);
   endtask

   task automatic frame(input logic [23:0] w, input int low_a = 66);
      send_bits(w, 0, 23);
      send_sync(low_a);
   endtask

   always @(negedge clk) begin
      if (valid || err) begin
         if (exp_q.size() == 0) begin
            check("unexpected_event", {30'b0, valid, err}, 32'd0);
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            check("event_kind", {30'b0, valid, err}, e.is_err ? 32'd1 : 32'd2);
            if (!e.is_err) check("valid_ad", {8'b0, ad}, {8'b0, e.word});
         end
      end
   end

   initial begin
      rst = 1'b1;
      d   = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_ad", ad, 0);
      check("rst_valid", valid, 0);
      check("rst_err", err, 0);
      check("rst_act", act, 0);
      hold(1'b0, 70);

      // Basic word, sent twice so both build variants publish it.
      exp_good(24'hAAAA01); frame(24'hAAAA01);
      check("t1_ad_first", ad, model_ad);
      exp_good(24'hAAAA01); frame(24'hAAAA01);
      check("t1_ad", ad, model_ad);

      // All-zero then all-one frames back to back.
      exp_good(24'h000000); frame(24'h000000);
      check("t2_ad_zero", ad, model_ad);
      exp_good(24'hFFFFFF); frame(24'hFFFFFF);
      check("t2_ad_ones", ad, model_ad);

      // 1-alpha high glitch at half-bit 5, then clean frames.
      exp_err();
      send_bits(24'h123456, 0, 4);
      hold(1'b1, 1); hold(1'b0, 15);
      send_bits(24'h123456, 6, 23);
      send_sync(66);
      check("t3_ad_kept", ad, model_ad);
      exp_good(24'h123456); frame(24'h123456);
      exp_good(24'h123456); frame(24'h123456);
      check("t3_ad", ad, model_ad);

      // Sync low 63 alpha fails, exactly 64 alpha succeeds.
      exp_err();
      frame(24'h5A5A5A, 63);
      hold(1'b1, 4); hold(1'b0, 66);
      check("t4_ad_kept", ad, model_ad);
      exp_good(24'h5A5A5A); frame(24'h5A5A5A, 64);
      exp_good(24'h5A5A5A); frame(24'h5A5A5A);
      check("t4_ad", ad, model_ad);

      // Short/short half-bit, then a low timeout mid-frame.
      exp_err();
      send_bits(24'h00F0F0, 0, 2);
      hold(1'b1, 4); hold(1'b0, 4);
      hold(1'b1, 2);
      check("t5_act_after_pair", act, 0);
      hold(1'b0, 66);
      exp_err();
      send_bits(24'h00F0F0, 0, 2);
      hold(1'b1, 4); hold(1'b0, 16);
      check("t5_act_at_16a_low", act, 1);
      hold(1'b0, 2);
      check("t5_act_after_timeout", act, 0);
      hold(1'b0, 52);
      exp_good(24'h00F0F0); frame(24'h00F0F0);
      exp_good(24'h00F0F0); frame(24'h00F0F0);
      check("t5_ad", ad, model_ad);

      // One-cycle reset at half-bit 12.
      send_bits(24'h3C3C3C, 0, 11);
      check("t6_act_before_rst", act, 1);
      rst = 1'b1;
      d   = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_ad = '0;
`ifdef PT_DEC_CONFIRM_EN
      ref_ok = 1'b0;
`endif
      check("t6_act_reset", act, 0);
      send_bits(24'h3C3C3C, 12, 23);
      send_sync(66);
      exp_good(24'h3C3C3C); frame(24'h3C3C3C);
      exp_good(24'h3C3C3C); frame(24'h3C3C3C);
      check("t6_ad", ad, model_ad);

      for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
